// File: rtl/home_ctrl_fsm_if.sv
// Sensor/actuator bundle for the home supervisory controller.
//   master : sensor side (drives SD, SW, SFA, ST, alarm_clr; observes actuators)
//   slave  : controller side (observes sensors; drives door_open, door_idx,
//            winbuzz, alarmbuzz, heater, cooler, display)
// SD/door_open are N_DOORS wide, ST is TW wide, door_idx is clog2(N_DOORS)
// wide with a minimum of 1, display is the 3-bit state code.
interface home_ctrl_fsm_if #(
  parameter int N_DOORS = 2,
  parameter int TW      = 7
);
  localparam int DIW = (N_DOORS > 1) ? $clog2(N_DOORS) : 1;

  logic [N_DOORS-1:0] SD;
  logic               SW;
  logic               SFA;
  logic [TW-1:0]      ST;
  logic               alarm_clr;

  logic [N_DOORS-1:0] door_open;
  logic [DIW-1:0]     door_idx;
  logic               winbuzz;
  logic               alarmbuzz;
  logic               heater;
  logic               cooler;
  logic [2:0]         display;

  modport master (
    output SD, SW, SFA, ST, alarm_clr,
    input  door_open, door_idx, winbuzz, alarmbuzz, heater, cooler, display
  );

  modport slave (
    input  SD, SW, SFA, ST, alarm_clr,
    output door_open, door_idx, winbuzz, alarmbuzz, heater, cooler, display
  );
endinterface

// File: rtl/home_ctrl_fsm.sv
// Smart-home supervisory controller.
// Debounces each door, window and fire sensor, tracks heating/cooling demand
// with hysteresis, and selects one active state with fixed priority
// ALARM > DOOR > WINDOW > HEAT/COOL > IDLE. The fire alarm latches until an
// acknowledge arrives while the debounced fire sensor is clear.
// Ports:
//   clk   - rising-edge clock
//   Rst_n - asynchronous active-low reset
//   bus   - home_ctrl_fsm_if.slave: raw sensors + temperature in,
//           registered actuators and state code (display) out
module home_ctrl_fsm #(
  parameter int N_DOORS = 2,
  parameter int TW      = 7,
  parameter int T_LOW   = 50,
  parameter int T_HIGH  = 60,
  parameter int HYST    = 2,
  parameter int DEB_CYC = 4
) (
  input logic            clk,
  input logic            Rst_n,
  home_ctrl_fsm_if.slave bus
);
  localparam int DIW = (N_DOORS > 1) ? $clog2(N_DOORS) : 1;
  localparam int CW  = $clog2(DEB_CYC + 1);

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYC - 1);
  localparam logic [TW-1:0] HEAT_ON_T  = TW'(T_LOW);
  localparam logic [TW-1:0] HEAT_OFF_T = TW'(T_LOW + HYST);
  localparam logic [TW-1:0] COOL_ON_T  = TW'(T_HIGH);
  localparam logic [TW-1:0] COOL_OFF_T = TW'(T_HIGH - HYST);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DOOR   = 3'd1,
    WINDOW = 3'd2,
    ALARM  = 3'd3,
    HEAT   = 3'd4,
    COOL   = 3'd5
  } state_t;

  // One debounce step: returns {debounced bit, counter}. The counter only
  // advances while raw disagrees with the accepted value; the accepting step
  // happens on the DEB_CYC-th consecutive disagreeing sample.
  function automatic logic [CW:0] deb_step(input logic          raw,
                                           input logic          d,
                                           input logic [CW-1:0] cnt);
    if (raw == d)             return {d, {CW{1'b0}}};
    else if (cnt == DEB_LAST) return {raw, {CW{1'b0}}};
    else                      return {d, cnt + CW'(1)};
  endfunction

  logic [N_DOORS-1:0] d_sd;
  logic [CW-1:0]      sd_cnt [N_DOORS];
  logic               d_sw,  d_sfa;
  logic [CW-1:0]      sw_cnt, sfa_cnt;

  logic               heat_f, cool_f;
  logic               alarm_lat;

  state_t             state, nxt;
  logic               door_any;
  logic [DIW-1:0]     door_sel;

  logic [N_DOORS-1:0] door_open_q;
  logic [DIW-1:0]     door_idx_q;
  logic               winbuzz_q, alarmbuzz_q, heater_q, cooler_q;

  // Sensor debounce
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      d_sd    <= '0;
      d_sw    <= 1'b0;
      d_sfa   <= 1'b0;
      sw_cnt  <= '0;
      sfa_cnt <= '0;
      for (int i = 0; i < N_DOORS; i++) sd_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_DOORS; i++)
        {d_sd[i], sd_cnt[i]} <= deb_step(bus.SD[i], d_sd[i], sd_cnt[i]);
      {d_sw,  sw_cnt}  <= deb_step(bus.SW,  d_sw,  sw_cnt);
      {d_sfa, sfa_cnt} <= deb_step(bus.SFA, d_sfa, sfa_cnt);
    end
  end

  // Climate hysteresis flags; inside the band each flag holds its value.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      heat_f <= 1'b0;
      cool_f <= 1'b0;
    end else begin
      if (bus.ST < HEAT_ON_T)        heat_f <= 1'b1;
      else if (bus.ST >= HEAT_OFF_T) heat_f <= 1'b0;
      if (bus.ST > COOL_ON_T)        cool_f <= 1'b1;
      else if (bus.ST <= COOL_OFF_T) cool_f <= 1'b0;
    end
  end

  // Lowest-index active door wins, so scan from the top down.
  always_comb begin
    door_any = |d_sd;
    door_sel = '0;
    for (int i = N_DOORS - 1; i >= 0; i--)
      if (d_sd[i]) door_sel = DIW'(i);
  end

  always_comb begin
    nxt = IDLE;
    if (state > COOL)                                nxt = IDLE;
    else if (d_sfa || (state == ALARM && alarm_lat)) nxt = ALARM;
    else if (door_any)                               nxt = DOOR;
    else if (d_sw)                                   nxt = WINDOW;
    else if (heat_f)                                 nxt = HEAT;
    else if (cool_f)                                 nxt = COOL;
  end

  // State, alarm latch and registered actuators. Clearing the latch takes
  // precedence so the acknowledge edge is followed by exactly one more ALARM
  // cycle before the state moves on.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      alarm_lat   <= 1'b0;
      door_open_q <= '0;
      door_idx_q  <= '0;
      winbuzz_q   <= 1'b0;
      alarmbuzz_q <= 1'b0;
      heater_q    <= 1'b0;
      cooler_q    <= 1'b0;
    end else begin
      state <= nxt;
      if (bus.alarm_clr && !d_sfa) alarm_lat <= 1'b0;
      else if (nxt == ALARM)       alarm_lat <= 1'b1;
      door_open_q <= (nxt == DOOR) ? (N_DOORS'(1) << door_sel) : '0;
      door_idx_q  <= (nxt == DOOR) ? door_sel : '0;
      winbuzz_q   <= (nxt == WINDOW);
      alarmbuzz_q <= (nxt == ALARM);
      heater_q    <= (nxt == HEAT);
      cooler_q    <= (nxt == COOL);
    end
  end

  assign bus.door_open = door_open_q;
  assign bus.door_idx  = door_idx_q;
  assign bus.winbuzz   = winbuzz_q;
  assign bus.alarmbuzz = alarmbuzz_q;
  assign bus.heater    = heater_q;
  assign bus.cooler    = cooler_q;
  assign bus.display   = state;
endmodule
